board_mem_writer: RTL and testbench

Write side of the board-state memory that the VGA pipeline reads through its re/raddr/state read port.
- Owns the board RAM and clears it after reset or on request.
- Accepts cell updates from game logic over a valid/ready handshake.
- Serves synchronous reads to the VGA side.
- Maintains the saturating score counter consumed by the display.

---
 rtl/board_mem_writer.sv | 113 +++++++++++
 tb/tb_board_mem_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_writer.sv
// Board-state RAM with a write side for game logic and a read port for the VGA side.
// It clears itself after reset or on request and keeps a saturating score counter.
module board_mem_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 600,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  input  logic              score_inc,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] state,
  output logic [9:0]        score,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} fsm_t;

  fsm_t              fsm, fsm_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [9:0]        score_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_data_p1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              wr_accept;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a <= LAST_ADDR;
  endfunction

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign wr_ready  = (fsm == READY);
  assign busy      = (fsm == CLEAR);
  assign wr_accept = wr_valid && (fsm == READY);
  assign score     = score_q;
  assign err       = err_q;
  assign state     = rd_data_p1;

  always_ff @(posedge clk) begin
    if (reset) fsm <= CLEAR;
    else       fsm <= fsm_nxt;
  end

  // The clear walk and the write handshake share the single RAM write port;
  // they are mutually exclusive by FSM state.
  always_comb begin
    fsm_nxt   = fsm;
    ram_we    = 1'b0;
    ram_waddr = clr_ptr;
    ram_wdata = CLEAR_VAL;
    case (fsm)
      CLEAR: begin
        ram_we = 1'b1;
        if (clr_ptr == LAST_ADDR) fsm_nxt = READY;
      end
      READY: begin
        if (wr_accept && in_range(wr_addr)) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = wr_data;
        end
        if (clr_req) fsm_nxt = CLEAR;
      end
      default: fsm_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
    end else if (fsm == CLEAR) begin
      clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + 1'b1;
    end else begin
      clr_ptr <= '0;
      if (clr_req) begin
        score_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (score_inc) score_q <= sat_inc(score_q);
        if (wr_accept && !in_range(wr_addr)) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Read stage: registered, read-first against a same-edge write.
  always_ff @(posedge clk) begin
    if (reset)   rd_data_p1 <= '0;
    else if (re) rd_data_p1 <= in_range(raddr) ? mem[raddr] : CLEAR_VAL;
  end

endmodule

// File: tb/tb_board_mem_writer.sv
// Self-checking bench for board_mem_writer: clear timing, writes, reads, error flag and score.
module tb_board_mem_writer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 600;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_req = 1'b0;
  logic              score_inc = 1'b0;
  logic              re = 1'b0;
  logic [ADDR_W-1:0] raddr = '0;
  logic [DATA_W-1:0] state;
  logic [9:0]        score;
  logic              busy;
  logic              err;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic              err_exp = 1'b0;
  int                score_exp = 0;

  board_mem_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_VAL('0)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .score_inc(score_inc),
    .re(re), .raddr(raddr), .state(state), .score(score), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Counts cycles until wr_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    wait_ready(n);
    tick();
    wr_valid = 1'b0;
    if (a < DEPTH) model[a] = d;
    else err_exp = 1'b1;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input string name);
    logic [DATA_W-1:0] e;
    re = 1'b1; raddr = a;
    exp_q.push_back((a < DEPTH) ? model[a] : '0);
    tick();
    re = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (state !== e) begin
      fails++;
      $display("FAIL %s addr=%0d got=%h expected=%h", name, a, state, e);
    end
  endtask

  task automatic check_ready_time(input int n, input int exp_n, input string name);
    tests++;
    if (n !== exp_n) begin
      fails++;
      $display("FAIL %s cycles_to_ready got=%0d expected=%0d", name, n, exp_n);
    end
  endtask

  task automatic check_score(input string name);
    tests++;
    if (score !== 10'(score_exp)) begin
      fails++;
      $display("FAIL %s score got=%0d expected=%0d", name, score, score_exp);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    wr_valid = 1'b1; wr_addr = 10'd3; wr_data = 16'hAAAA;
    tick(); tick();
    tests++;
    if ({wr_ready, busy, err} !== 3'b010 || state !== 16'h0 || score !== 10'd0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b busy=%b err=%b state=%h score=%0d expected 0 1 0 0000 0",
               wr_ready, busy, err, state, score);
    end
    reset = 1'b0;
    wait_ready(n);
    check_ready_time(n, DEPTH, "reset_clear_len");
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy got=%b expected=0", busy);
    end
    tick();
    wr_valid = 1'b0;
    clear_model();
    model[3] = 16'hAAAA;
    for (int i = 0; i < DEPTH; i++) do_read(10'(i), "sweep_after_reset");
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] held;
    do_write(10'd5, 16'hBEEF);
    do_read(10'd5, "read_after_write");
    // Same-edge write and read: old word expected.
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 16'h1234;
    re = 1'b1; raddr = 10'd5;
    exp_q.push_back(model[5]);
    tick();
    wr_valid = 1'b0; re = 1'b0;
    model[5] = 16'h1234;
    held = exp_q.pop_front();
    tests++;
    if (state !== held) begin
      fails++;
      $display("FAIL read_first got=%h expected=%h", state, held);
    end
    raddr = 10'd3;
    tick(); tick();
    tests++;
    if (state !== held) begin
      fails++;
      $display("FAIL re_low_hold got=%h expected=%h", state, held);
    end
    do_read(10'd5, "read_new_word");
    do_write(10'd599, 16'h0F0F);
    do_read(10'd599, "read_last_addr");
  endtask

  task automatic test_oob();
    do_write(10'd700, 16'hFFFF);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL oob_err got=%b expected=1", err);
    end
    tick(); tick();
    do_write(10'd7, 16'h0007);
    tests++;
    if (err !== err_exp) begin
      fails++;
      $display("FAIL oob_err_sticky got=%b expected=%b", err, err_exp);
    end
    do_read(10'd700, "oob_read");
    do_read(10'd599, "oob_no_alias");
    do_read(10'd100, "oob_no_alias_100");
  endtask

  task automatic test_score();
    int n;
    for (int i = 0; i < 1030; i++) begin
      score_inc = 1'b1;
      tick();
      score_exp = (score_exp < 1023) ? score_exp + 1 : 1023;
      if (i < 3) check_score("score_count");
    end
    score_inc = 1'b0;
    check_score("score_saturate");
    score_inc = 1'b1; clr_req = 1'b1;
    tick();
    score_inc = 1'b0; clr_req = 1'b0;
    score_exp = 0;
    err_exp = 1'b0;
    check_score("score_clr_wins");
    tests++;
    if ({busy, wr_ready, err} !== 3'b100) begin
      fails++;
      $display("FAIL clr_enter got busy=%b rdy=%b err=%b expected 1 0 0", busy, wr_ready, err);
    end
    score_inc = 1'b1;
    tick();
    score_inc = 1'b0;
    check_score("score_ignored_in_clear");
    wait_ready(n);
    check_ready_time(n, DEPTH - 1, "clr_req_clear_len");
    clear_model();
    do_read(10'd5, "addr5_after_clear");
    do_read(10'd599, "addr599_after_clear");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    do_write(10'd599, 16'h5A5A);
    do_read(10'd599, "pre_clear_599");
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 299; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    check_ready_time(n, DEPTH, "reset_mid_clear_len");
    clear_model();
    do_read(10'd599, "mid_reset_599");
    do_read(10'd0, "mid_reset_0");
  endtask

  task automatic test_clr_ignored();
    int n;
    do_write(10'd450, 16'h4545);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    clr_req = 1'b1; score_inc = 1'b1;
    tick();
    clr_req = 1'b0; score_inc = 1'b0;
    // Pointer is near 100: address 450 still holds the old word during CLEAR.
    do_read(10'd450, "read_during_clear");
    wait_ready(n);
    check_ready_time(n, DEPTH - 101, "clr_ignored_in_clear");
    check_score("score_after_clr_ignored");
    clear_model();
    do_read(10'd450, "after_clear_450");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_oob();
    test_score();
    test_reset_mid_clear();
    test_clr_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
